// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - up/down modulo counter with programmable limit, wrap/saturate modes
// Optional prescaler compiled in with `define MOD_COUNTER_PRESCALE_EN (PRESCALE enabled cycles per step).
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] Q,
  output logic             at_end,
  output logic             wrap,
  output logic             sat_hit
);

  // Counting is requested only when neither clear nor load owns the edge.
  logic step_en;
  logic tick;
  logic at_top;
  logic at_zero;

  assign step_en = en & ~clear & ~load;

  // PRESCALE outside 2..256 has no meaning; the block below marks such a build.
  generate
    if ((PRESCALE < 2) || (PRESCALE > 256)) begin : g_prescale_out_of_range
    end
  endgenerate

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  // Prescaler: counts enabled cycles, restarts on clear/load/reset and after each step.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      pre_cnt <= '0;
    end else if (clear || load) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    end
  end

  assign tick = step_en & (pre_cnt == PRE_LAST);
`else
  assign tick = step_en;
`endif

  // Range compares; Q may sit above limit after limit is lowered, so up uses >=.
  assign at_top  = (Q >= limit);
  assign at_zero = (Q == '0);
  assign at_end  = up ? at_top : at_zero;

  // Count state: clear beats load beats step; wrap is a one-cycle pulse after a wrap step.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      Q       <= '0;
      wrap    <= 1'b0;
      sat_hit <= 1'b0;
    end else if (clear) begin
      Q       <= '0;
      wrap    <= 1'b0;
      sat_hit <= 1'b0;
    end else if (load) begin
      Q    <= (D > limit) ? limit : D;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (tick) begin
        if (up) begin
          if (!at_top) begin
            Q <= Q + 1'b1;
          end else if (!sat) begin
            Q    <= '0;
            wrap <= 1'b1;
          end else begin
            sat_hit <= 1'b1;
          end
        end else begin
          if (!at_zero) begin
            Q <= Q - 1'b1;
          end else if (!sat) begin
            Q    <= limit;
            wrap <= 1'b1;
          end else begin
            sat_hit <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - self-checking bench for mod_counter (either prescale build)
module tb_mod_counter;

  localparam int P = 4;
`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int PS = P;
`else
  localparam int PS = 1;
`endif

  logic       clock = 1'b0;
  logic       reset_L, en, clear, load, up, sat;
  logic [7:0] D, limit, Q;
  logic       at_end, wrap, sat_hit;

  int total = 0;
  int bad   = 0;

  // Reference state in plain integers.
  int m_q;
  int m_pre;
  bit m_wrap;
  bit m_sat;

  mod_counter #(.WIDTH(8), .PRESCALE(P)) dut (
    .clock(clock), .reset_L(reset_L), .en(en), .clear(clear), .load(load),
    .up(up), .sat(sat), .D(D), .limit(limit), .Q(Q), .at_end(at_end),
    .wrap(wrap), .sat_hit(sat_hit)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_pre = 0; m_wrap = 0; m_sat = 0;
  endtask

  // One clock edge of the counter, from the written rules.
  task automatic model_edge();
    bit go;
    int lim;
    lim = int'(limit);
    if (clear) begin
      model_reset();
    end else if (load) begin
      m_q    = (int'(D) > lim) ? lim : int'(D);
      m_pre  = 0;
      m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (en) begin
        if (PS > 1) begin
          go    = (m_pre == PS - 1);
          m_pre = go ? 0 : m_pre + 1;
        end else begin
          go = 1;
        end
        if (go) begin
          if (up) begin
            if (m_q < lim)  m_q = m_q + 1;
            else if (!sat) begin m_q = 0; m_wrap = 1; end
            else m_sat = 1;
          end else begin
            if (m_q > 0)    m_q = m_q - 1;
            else if (!sat) begin m_q = lim; m_wrap = 1; end
            else m_sat = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit e;
    e = up ? (m_q >= int'(limit)) : (m_q == 0);
    check({tag, ".q"}, Q, m_q);
    check({tag, ".wrap"}, wrap, m_wrap);
    check({tag, ".sat_hit"}, sat_hit, m_sat);
    check({tag, ".at_end"}, at_end, e);
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all(tag);
  endtask

  initial begin
    reset_L = 1'b0; en = 0; clear = 0; load = 0; up = 0; sat = 0;
    D = 8'd0; limit = 8'd5;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clock);
    reset_L = 1'b1;

    // Up count with wrap at limit=5.
    up = 1; sat = 0; en = 1; limit = 8'd5;
    for (int i = 0; i < 7 * PS; i++) begin
      step("up_wrap");
      check("up_wrap.seq_q", Q, ((i + 1) / PS) % 6);
      check("up_wrap.seq_wrap", wrap, (((i + 1) % PS) == 0) && (((i + 1) / PS) == 6));
    end

    // Down saturate at zero; sat_hit sticky until clear.
    clear = 1; step("clr1"); clear = 0;
    up = 0; sat = 1; en = 1;
    for (int i = 0; i < 3 * PS; i++) begin
      step("down_sat");
      check("down_sat.at_end", at_end, 1);
    end
    check("down_sat.q", Q, 0);
    check("down_sat.sticky", sat_hit, 1);
    en = 0; up = 1;
    step("sticky_hold");
    check("sticky_hold.sat_hit", sat_hit, 1);
    clear = 1; step("clr2"); clear = 0;
    check("clr2.sat_hit", sat_hit, 0);

    // Load clamps to limit, then wrap from the top.
    limit = 8'd9; D = 8'd200; load = 1;
    step("load_clamp");
    check("load_clamp.q", Q, 9);
    load = 0; up = 1; sat = 0; en = 1;
    for (int i = 0; i < PS; i++) step("load_wrap");
    check("load_wrap.q", Q, 0);
    check("load_wrap.wrap", wrap, 1);

    // Clear beats load and step.
    D = 8'd7; load = 1; en = 0; step("load7");
    check("load7.q", Q, 7);
    clear = 1; load = 1; en = 1; D = 8'd3;
    step("clr_prio");
    check("clr_prio.q", Q, 0);
    check("clr_prio.wrap", wrap, 0);
    check("clr_prio.sat_hit", sat_hit, 0);
    clear = 0; load = 0; en = 0;

    // Asynchronous reset between edges with a step pending.
    D = 8'd3; load = 1; step("pre_rst_load"); load = 0;
    limit = 8'd255; up = 1; sat = 0; en = 1;
    for (int i = 0; i < PS - 1; i++) step("pre_rst_cnt");
    check("pre_rst.q", Q, 3);
    #1 reset_L = 1'b0;
    #1;
    model_reset();
    check("async_rst.q", Q, 0);
    check("async_rst.wrap", wrap, 0);
    check("async_rst.sat_hit", sat_hit, 0);
    #1 reset_L = 1'b1;
    for (int i = 0; i < PS; i++) begin
      step("post_rst");
      check("post_rst.first_step", Q, (i + 1) == PS);
    end

    // Randomised run against the reference model.
    for (int i = 0; i < 600; i++) begin
      clear = ($urandom_range(0, 31) == 0);
      load  = ($urandom_range(0, 15) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up    = $urandom_range(0, 1);
      sat   = $urandom_range(0, 1);
      D     = 8'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 4))
          0: limit = 8'd0;
          1: limit = 8'd1;
          2: limit = 8'd5;
          3: limit = 8'd255;
          default: limit = 8'($urandom);
        endcase
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
